// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the CAM arbiter.
// Entry 0 of the CAM is never allocated and doubles as the miss code.
package cam_pkg;

    localparam int DATA_W   = 8;
    localparam int IDX_W    = 5;
    localparam int DEPTH    = 1 << IDX_W;
    localparam int MISS_IDX = 0;

    localparam logic OP_LOOKUP = 1'b0;
    localparam logic OP_INSERT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_INSERT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/cam_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
// The pointer register itself is owned by the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_grant
);

    int pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        pos       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = (int'(ptr) + i) % N_REQ;
            if (!any_grant && req[pos]) begin
                any_grant  = 1'b1;
                grant_idx  = PTR_W'(pos);
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_arbiter.sv
// Round-robin front end sharing one CAM between N_REQ requesters.
// Sequences lookup / insert-if-absent and allocates entries from a free pointer.
module cam_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = cam_pkg::DATA_W,
    parameter int IDX_W  = cam_pkg::IDX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_op,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [IDX_W-1:0]        resp_idx,
    output logic                    resp_hit,
    output logic                    resp_full,
    output logic [IDX_W-1:0]        used,
    output logic                    full,
    output logic                    cam_enable,
    output logic                    cam_write,
    output logic [IDX_W-1:0]        cam_addr,
    output logic [DATA_W-1:0]       cam_data,
    input  logic [IDX_W-1:0]        cam_out
);
    import cam_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);
    localparam int SLOTS = 1 << IDX_W;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   owner;
    logic               any_gnt;
    logic               op;
    logic [DATA_W-1:0]  key;
    logic [IDX_W:0]     alloc_ptr;
    logic               cam_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any_grant (any_gnt)
    );

    // alloc_ptr runs 1..SLOTS; reaching SLOTS means every usable entry is taken
    assign used    = IDX_W'(alloc_ptr - 1'b1);
    assign full    = (alloc_ptr == (IDX_W+1)'(SLOTS));
    assign cam_hit = (cam_out != IDX_W'(MISS_IDX));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (any_gnt) state_nxt = S_LOOKUP;
            S_LOOKUP: state_nxt = S_CHECK;
            S_CHECK: begin
                if (cam_hit || op == OP_LOOKUP || full) state_nxt = S_RESP;
                else                                    state_nxt = S_INSERT;
            end
            S_INSERT: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ack        = '0;
        cam_enable = 1'b0;
        cam_write  = 1'b0;
        cam_addr   = '0;
        cam_data   = '0;
        unique case (state)
            S_LOOKUP: begin
                cam_enable = 1'b1;
                cam_data   = key;
            end
            S_INSERT: begin
                cam_write = 1'b1;
                cam_addr  = alloc_ptr[IDX_W-1:0];
                cam_data  = key;
            end
            S_RESP:  ack = owner;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            owner     <= '0;
            op        <= OP_LOOKUP;
            key       <= '0;
            alloc_ptr <= (IDX_W+1)'(1);
            resp_idx  <= '0;
            resp_hit  <= 1'b0;
            resp_full <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (any_gnt) begin
                    owner  <= gnt;
                    op     <= req_op[gnt_idx];
                    key    <= req_data[gnt_idx*DATA_W +: DATA_W];
                    rr_ptr <= (int'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
                end
                S_CHECK: begin
                    if (cam_hit) begin
                        resp_idx  <= cam_out;
                        resp_hit  <= 1'b1;
                        resp_full <= 1'b0;
                    end else if (op == OP_LOOKUP || full) begin
                        resp_idx  <= IDX_W'(MISS_IDX);
                        resp_hit  <= 1'b0;
                        resp_full <= (op == OP_INSERT);
                    end
                end
                S_INSERT: begin
                    resp_idx  <= alloc_ptr[IDX_W-1:0];
                    resp_hit  <= 1'b0;
                    resp_full <= 1'b0;
                    if (!full) alloc_ptr <= alloc_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_arbiter.sv
// Testbench for cam_arbiter with a behavioural CAM and a queue-based table model.
// Random request batches are checked against round-robin and allocation rules.
module tb_cam_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_op = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [4:0]  resp_idx;
    logic        resp_hit;
    logic        resp_full;
    logic [4:0]  used;
    logic        full;
    logic        cam_enable;
    logic        cam_write;
    logic [4:0]  cam_addr;
    logic [7:0]  cam_data;
    logic [4:0]  cam_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cam_arbiter #(.N_REQ(4), .DATA_W(8), .IDX_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_op     (req_op),
        .req_data   (req_data),
        .ack        (ack),
        .resp_idx   (resp_idx),
        .resp_hit   (resp_hit),
        .resp_full  (resp_full),
        .used       (used),
        .full       (full),
        .cam_enable (cam_enable),
        .cam_write  (cam_write),
        .cam_addr   (cam_addr),
        .cam_data   (cam_data),
        .cam_out    (cam_out)
    );

    // Behavioural CAM: registered lowest-index match, cleared by the shared reset
    logic [7:0] cam_key [32];
    logic       cam_vld [32];

    function automatic logic [4:0] cam_match(input logic [7:0] k);
        for (int i = 1; i < 32; i++)
            if (cam_vld[i] && cam_key[i] == k) return 5'(i);
        return 5'd0;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) cam_vld[i] <= 1'b0;
            cam_out <= '0;
        end else begin
            if (cam_write) begin
                cam_vld[cam_addr] <= 1'b1;
                cam_key[cam_addr] <= cam_data;
            end
            if (cam_enable) cam_out <= cam_match(cam_data);
        end
    end

    // Reference model: stored keys in allocation order, key at position p owns index p+1
    logic [7:0] mkeys[$];
    int         rr_m;
    int         ord[$];

    function automatic void model_apply(input logic op, input logic [7:0] k,
                                        output logic [4:0] idx, output logic hit,
                                        output logic fl, output logic wr);
        int pos = -1;
        foreach (mkeys[i]) if (pos < 0 && mkeys[i] == k) pos = i;
        idx = 5'd0; hit = 1'b0; fl = 1'b0; wr = 1'b0;
        if (pos >= 0) begin
            idx = 5'(pos + 1);
            hit = 1'b1;
        end else if (op) begin
            if (mkeys.size() == 31) fl = 1'b1;
            else begin
                mkeys.push_back(k);
                idx = 5'(mkeys.size());
                wr  = 1'b1;
            end
        end
    endfunction

    function automatic void plan(input logic [3:0] mask);
        logic [3:0] p = mask;
        ord.delete();
        while (p != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int j = (rr_m + k) % 4;
                if (p[j]) begin
                    ord.push_back(j);
                    p[j] = 1'b0;
                    rr_m = (j + 1) % 4;
                    break;
                end
            end
        end
    endfunction

    // Driver results
    int         g_who[$];
    logic [4:0] g_idx[$];
    logic       g_hit[$];
    logic       g_full[$];
    int         g_cyc[$];
    logic [7:0] en_data[$];
    logic [4:0] wr_addr[$];
    int         proto_err;
    bit         timed_out;

    task automatic drive(input logic [3:0] mask, input logic [3:0] ops,
                         input logic [31:0] keys);
        logic [3:0] pend;
        g_who.delete(); g_idx.delete(); g_hit.delete(); g_full.delete();
        g_cyc.delete(); en_data.delete(); wr_addr.delete();
        proto_err = 0;
        timed_out = 1'b0;
        @(posedge clk); #1;
        req_op = ops; req_data = keys; req = mask; pend = mask;
        for (int c = 1; c <= 40 && pend != 4'b0000; c++) begin
            @(posedge clk); #1;
            if (cam_enable) en_data.push_back(cam_data);
            if (cam_write) wr_addr.push_back(cam_addr);
            if (cam_enable && cam_write) proto_err++;
            if (!cam_enable && !cam_write && cam_data != 8'h00) proto_err++;
            if (ack != 4'b0000) begin
                int w = -1;
                for (int k = 0; k < 4; k++) if (ack[k]) w = (w == -1) ? k : 99;
                g_who.push_back(w); g_idx.push_back(resp_idx);
                g_hit.push_back(resp_hit); g_full.push_back(resp_full);
                g_cyc.push_back(c);
                pend = pend & ~ack;
                req  = req & ~ack;
            end
        end
        if (pend != 4'b0000) timed_out = 1'b1;
        req = '0;
        @(posedge clk); #1;
        if (ack != 4'b0000) proto_err++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mkeys.delete();
        rr_m = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (5) @(posedge clk);
        #1;
        tests++; if (ack !== 4'b0) begin fails++; $display("FAIL reset_ack got %b want 0000", ack); end
        tests++; if (cam_enable !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", cam_enable); end
        tests++; if (cam_write !== 1'b0) begin fails++; $display("FAIL reset_wr got %b want 0", cam_write); end
        tests++; if (used !== 5'd0) begin fails++; $display("FAIL reset_used got %0d want 0", used); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
        tests++; if (resp_idx !== 5'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", resp_idx); end
        tests++; if (cam_data !== 8'd0) begin fails++; $display("FAIL reset_data got %0h want 0", cam_data); end
    endtask

    task automatic test_insert_lookup();
        int         tr[4] = '{0, 1, 1, 2};
        logic       tp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] tk[4] = '{8'hA5, 8'hA5, 8'h3C, 8'hA5};
        for (int i = 0; i < 4; i++) begin
            logic [4:0] ei;
            logic       eh, ef, ew;
            int         gw;
            drive(4'(1 << tr[i]), {4{tp[i]}}, {4{tk[i]}});
            model_apply(tp[i], tk[i], ei, eh, ef, ew);
            rr_m = (tr[i] + 1) % 4;
            gw = g_who.size() > 0 ? g_who[0] : -1;
            tests++; if (timed_out) begin fails++; $display("FAIL single%0d_timeout no ack seen", i); end
            tests++; if (gw != tr[i]) begin fails++; $display("FAIL single%0d_who got %0d want %0d", i, gw, tr[i]); end
            if (g_who.size() > 0) begin
                tests++; if (g_idx[0] !== ei) begin fails++; $display("FAIL single%0d_idx got %0d want %0d", i, g_idx[0], ei); end
                tests++; if (g_hit[0] !== eh) begin fails++; $display("FAIL single%0d_hit got %b want %b", i, g_hit[0], eh); end
                tests++; if (g_full[0] !== ef) begin fails++; $display("FAIL single%0d_full got %b want %b", i, g_full[0], ef); end
                tests++; if (g_cyc[0] != (ew ? 4 : 3)) begin fails++; $display("FAIL single%0d_lat got %0d want %0d", i, g_cyc[0], ew ? 4 : 3); end
            end
            tests++; if (wr_addr.size() != int'(ew)) begin fails++; $display("FAIL single%0d_writes got %0d want %0d", i, wr_addr.size(), ew); end
            tests++; if (en_data.size() != 1 || en_data[0] !== tk[i]) begin fails++; $display("FAIL single%0d_lookup_key got %0d strobes want one with %0h", i, en_data.size(), tk[i]); end
            tests++; if (int'(used) != mkeys.size()) begin fails++; $display("FAIL single%0d_used got %0d want %0d", i, used, mkeys.size()); end
            tests++; if (proto_err != 0) begin fails++; $display("FAIL single%0d_strobes got %0d errors want 0", i, proto_err); end
            if (i == 0 && wr_addr.size() > 0) begin
                tests++; if (wr_addr[0] !== 5'd1) begin fails++; $display("FAIL first_alloc_addr got %0d want 1", wr_addr[0]); end
            end
        end
    endtask

    task automatic check_batch(input string tag, input logic [3:0] mask,
                               input logic [3:0] ops, input logic [31:0] keys);
        int nw = 0;
        int elat = 0;
        drive(mask, ops, keys);
        plan(mask);
        tests++; if (timed_out) begin fails++; $display("FAIL %s_timeout got %0d acks want %0d", tag, g_who.size(), ord.size()); end
        tests++; if (g_who.size() != ord.size()) begin fails++; $display("FAIL %s_count got %0d want %0d", tag, g_who.size(), ord.size()); end
        foreach (ord[k]) begin
            int         r = ord[k];
            logic [7:0] key = keys[r*8 +: 8];
            logic [4:0] ei;
            logic       eh, ef, ew;
            model_apply(ops[r], key, ei, eh, ef, ew);
            nw += int'(ew);
            if (k == 0) elat = ew ? 4 : 3;
            if (k < g_who.size()) begin
                tests++; if (g_who[k] != r) begin fails++; $display("FAIL %s_order%0d got %0d want %0d", tag, k, g_who[k], r); end
                tests++; if (g_idx[k] !== ei || g_hit[k] !== eh || g_full[k] !== ef) begin
                    fails++; $display("FAIL %s_resp%0d got idx=%0d hit=%b full=%b want idx=%0d hit=%b full=%b",
                                      tag, k, g_idx[k], g_hit[k], g_full[k], ei, eh, ef);
                end
            end
            if (k < en_data.size()) begin
                tests++; if (en_data[k] !== key) begin fails++; $display("FAIL %s_key%0d got %0h want %0h", tag, k, en_data[k], key); end
            end
        end
        if (g_cyc.size() > 0) begin
            tests++; if (g_cyc[0] != elat) begin fails++; $display("FAIL %s_latency got %0d want %0d", tag, g_cyc[0], elat); end
        end
        tests++; if (wr_addr.size() != nw) begin fails++; $display("FAIL %s_writes got %0d want %0d", tag, wr_addr.size(), nw); end
        tests++; if (proto_err != 0) begin fails++; $display("FAIL %s_strobes got %0d errors want 0", tag, proto_err); end
        tests++; if (int'(used) != mkeys.size() || full !== (mkeys.size() == 31)) begin
            fails++; $display("FAIL %s_occupancy got used=%0d full=%b want used=%0d", tag, used, full, mkeys.size());
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        check_batch("rr_seed", 4'b1000, 4'b1111, {4{8'hA5}});
        check_batch("rr_all", 4'b1111, 4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
        tests++; if (resp_idx !== 5'd5) begin fails++; $display("FAIL rr_last_idx got %0d want 5", resp_idx); end
    endtask

    task automatic test_fill();
        int n = 0;
        while (mkeys.size() < 31 && n < 40) begin
            logic [7:0] k = 8'h80 + 8'(n);
            check_batch("fill", 4'(1 << (n % 4)), 4'b1111, {4{k}});
            n++;
        end
        tests++; if (used !== 5'd31 || full !== 1'b1) begin fails++; $display("FAIL filled got used=%0d full=%b want 31/1", used, full); end
        check_batch("full_ins", 4'b0100, 4'b1111, {4{8'h77}});
        tests++; if (resp_full !== 1'b1 || resp_idx !== 5'd0) begin fails++; $display("FAIL full_refuse got full=%b idx=%0d want 1/0", resp_full, resp_idx); end
        check_batch("full_look", 4'b0010, 4'b0000, {4{8'h10}});
        tests++; if (resp_hit !== 1'b1 || resp_idx !== 5'd2) begin fails++; $display("FAIL full_hit got hit=%b idx=%0d want 1/2", resp_hit, resp_idx); end
    endtask

    task automatic test_reset_mid_insert();
        int acks = 0;
        apply_reset();
        @(posedge clk); #1;
        req_op = 4'b0010; req_data = {4{8'h5A}}; req = 4'b0010;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (cam_write !== 1'b1) begin fails++; $display("FAIL midrst_in_insert got wr=%b want 1", cam_write); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        req = '0;
        if (ack != 4'b0) acks++;
        tests++; if (used !== 5'd0) begin fails++; $display("FAIL midrst_used got %0d want 0", used); end
        tests++; if (cam_write !== 1'b0) begin fails++; $display("FAIL midrst_wr got %b want 0", cam_write); end
        rst_n = 1'b1;
        mkeys.delete();
        rr_m = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack != 4'b0) acks++;
        end
        tests++; if (acks != 0) begin fails++; $display("FAIL midrst_ack got %0d acks want 0", acks); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int b = 0; b < 40; b++) begin
            logic [3:0]  mask = 4'($urandom_range(1, 15));
            logic [3:0]  ops  = 4'($urandom);
            logic [31:0] keys;
            for (int r = 0; r < 4; r++) keys[r*8 +: 8] = 8'($urandom_range(0, 47));
            check_batch("rand", mask, ops, keys);
        end
    endtask

    initial begin
        rr_m = 0;
        test_reset();
        test_insert_lookup();
        test_round_robin();
        test_fill();
        test_reset_mid_insert();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
